// File: rtl/mac_prog_sequencer.sv
// mac_prog_sequencer
//  On-chip instruction issuer for the tt_um_mac datapath. A small program
//  memory holds {instr, operand} byte pairs. A run streams them out one per
//  cycle. After each EMIT (opcode 11) the sequencer pauses, captures the MAC
//  result from result_in and then resumes.
//
//  Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ena                  clock enable; 0 freezes every register
//   start, abort         begin a run (IDLE only) / cancel a run (any state)
//   prog_len             entries to run, clamped to DEPTH
//   wr_en/addr/data      program write port, honoured in IDLE only
//   instr_out,
//   operand_out,
//   issue_valid          issued entry (NOP 0x00/0x00 when not issuing)
//   result_in            MAC uo_out
//   result_out,
//   result_valid         last captured result, 1-cycle update pulse
//   busy, done           run in progress / 1-cycle normal completion pulse
//   pc_debug,
//   state_debug          next entry index, 00 IDLE 01 RUN 10 WAIT
module mac_prog_sequencer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int RESULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [7:0]        instr_out,
  output logic [7:0]        operand_out,
  output logic              issue_valid,
  input  logic [7:0]        result_in,
  output logic [7:0]        result_out,
  output logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pc_debug,
  output logic [1:0]        state_debug
);

  localparam int              CNT_W    = (RESULT_LAT > 2) ? $clog2(RESULT_LAT) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESULT_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        instr_q, instr_d;
  logic [7:0]        operand_q, operand_d;
  logic              issue_valid_q, issue_valid_d;
  logic [7:0]        result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              done_q, done_d;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic [ADDR_W:0]   clamp_len;
  logic              last_emit;
  logic              cnt_last;

  // Program memory: no reset, so contents survive rst_n. Writes only land
  // while idle; a write coinciding with start still lands, while entry 0 is
  // read from the pre-write contents on that same edge.
  always_ff @(posedge clk) begin
    if (ena && wr_en && (state_q == S_IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data   = mem[rd_addr];
  assign clamp_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  // The entry currently on the outputs is an EMIT.
  assign last_emit = issue_valid_q && (instr_q[7:6] == 2'b11);
  // WAIT is entered one edge after the EMIT issue, so a latency of 1 cannot
  // be shortened further and captures at the same point as a latency of 2.
  assign cnt_last  = (cnt_q == '0) || (cnt_q == CNT_W'(1));

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    instr_d        = 8'h00;
    operand_d      = 8'h00;
    issue_valid_d  = 1'b0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;
    rd_addr        = pc_q[ADDR_W-1:0];

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (clamp_len != '0) begin
              rd_addr       = '0;
              {instr_d, operand_d} = rd_data;
              issue_valid_d = 1'b1;
              pc_d          = (ADDR_W + 1)'(1);
              len_d         = clamp_len;
              state_d       = S_RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (last_emit) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end else if (pc_q < len_q) begin
            {instr_d, operand_d} = rd_data;
            issue_valid_d = 1'b1;
            pc_d          = pc_q + (ADDR_W + 1)'(1);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_last) begin
            cnt_d          = '0;
            result_d       = result_in;
            result_valid_d = 1'b1;
            if (pc_q < len_q) begin
              state_d = S_RUN;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      instr_q        <= 8'h00;
      operand_q      <= 8'h00;
      issue_valid_q  <= 1'b0;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else if (ena) begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      instr_q        <= instr_d;
      operand_q      <= operand_d;
      issue_valid_q  <= issue_valid_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  assign instr_out    = instr_q;
  assign operand_out  = operand_q;
  assign issue_valid  = issue_valid_q;
  assign result_out   = result_q;
  assign result_valid = result_valid_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);
  assign pc_debug     = pc_q;
  assign state_debug  = state_q;

endmodule

// File: tb/tb_mac_prog_sequencer.sv
// Testbench for mac_prog_sequencer. Stimulus tasks build the expected event
// stream of each run (issues, result captures, done) from the program and
// push it into a queue stamped with the enabled-cycle index; a negedge
// monitor pops and compares every event the DUT presents.
module tb_mac_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] prog_len = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0] instr_out, operand_out, result_in, result_out;
  logic       issue_valid, result_valid, busy, done;
  logic [4:0] pc_debug;
  logic [1:0] state_debug;

  mac_prog_sequencer #(.DEPTH(16), .ADDR_W(4), .RESULT_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .prog_len(prog_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .instr_out(instr_out), .operand_out(operand_out), .issue_valid(issue_valid),
    .result_in(result_in), .result_out(result_out), .result_valid(result_valid),
    .busy(busy), .done(done), .pc_debug(pc_debug), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  localparam int EV_ISSUE = 0;
  localparam int EV_RES   = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] data;
  } ev_t;

  ev_t         expq[$];
  logic [15:0] mem_m [16];
  logic [7:0]  rin [1024];
  logic        force_en = 1'b0;
  logic [7:0]  force_val = 8'h00;
  int          acyc = 0;
  logic        last_active = 1'b0;
  logic        mon_off = 1'b0;
  int          nvec = 0;
  int          nerr = 0;
  logic [34:0] obs, snap = '0;

  // result_in is a fixed pseudo-random function of the enabled-cycle index,
  // so the expected capture value is known when a run is planned.
  assign result_in = force_en ? force_val : rin[acyc % 1024];
  assign obs = {instr_out, operand_out, issue_valid, result_out, result_valid,
                done, busy, pc_debug, state_debug};

  always @(posedge clk) begin
    last_active <= rst_n && ena;
    if (rst_n && ena) acyc <= acyc + 1;
  end

  function automatic logic [7:0] rin_at(input int c);
    return force_en ? force_val : rin[c % 1024];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic pop_check(input int kind, input logic [15:0] data);
    ev_t e;
    nvec++;
    if (expq.size() == 0) begin
      nerr++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%h expected none", kind, acyc, data);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cyc != acyc || e.data !== data) begin
        nerr++;
        $display("FAIL event: got kind=%0d cyc=%0d data=%h expected kind=%0d cyc=%0d data=%h",
                 kind, acyc, data, e.kind, e.cyc, e.data);
      end else begin
        $display("event kind=%0d cyc=%0d data=%h ok", kind, acyc, data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !mon_off) begin
      if (last_active) begin
        if (issue_valid) pop_check(EV_ISSUE, {instr_out, operand_out});
        else chk("nop_when_idle", {16'h0, instr_out, operand_out}, 32'h0);
        if (result_valid) pop_check(EV_RES, {8'h00, result_out});
        if (done) pop_check(EV_DONE, 16'h0000);
        while (expq.size() > 0 && expq[0].cyc <= acyc) begin
          nvec++;
          nerr++;
          $display("FAIL missing_event: got nothing expected kind=%0d cyc=%0d data=%h",
                   expq[0].kind, expq[0].cyc, expq[0].data);
          void'(expq.pop_front());
        end
      end else begin
        chk("frozen_outputs", {29'h0, obs[34:32]}, {29'h0, snap[34:32]});
        chk("frozen_outputs_lo", obs[31:0], snap[31:0]);
      end
    end
    snap = obs;
  end

  task automatic wait_until(input int target);
    int g = 0;
    while (acyc < target && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    chk("wait_bound", {31'h0, acyc >= target}, 32'h1);
  endtask

  task automatic wr_prog(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  // Plan one run from the program semantics, then drive it.
  task automatic do_run(input int len_req, input int abort_at, input int pause_at,
                        input bit wr_with_start, input logic [3:0] waddr,
                        input logic [15:0] wdata, input bit wr_during);
    int s, len, t, last, abort_cyc;
    logic [15:0] v, pre0;
    s = acyc;
    len = (len_req > 16) ? 16 : len_req;
    pre0 = mem_m[0];
    if (wr_with_start) mem_m[waddr] = wdata;
    t = s + 1; last = s + 1; abort_cyc = -1;
    if (len == 0) expq.push_back('{EV_DONE, s + 1, 16'h0});
    for (int i = 0; i < len; i++) begin
      v = (i == 0) ? pre0 : mem_m[i];
      expq.push_back('{EV_ISSUE, t, v});
      if (abort_at == i + 1) begin
        abort_cyc = t; last = t;
        break;
      end
      if (v[15:14] == 2'b11) begin
        expq.push_back('{EV_RES, t + 2, {8'h00, rin_at(t + 1)}});
        if (i == len - 1) begin
          expq.push_back('{EV_DONE, t + 2, 16'h0});
          last = t + 2;
        end
        t += 3;
      end else begin
        if (i == len - 1) begin
          expq.push_back('{EV_DONE, t + 1, 16'h0});
          last = t + 1;
        end
        t += 1;
      end
    end
    start = 1'b1; prog_len = 5'(len_req);
    wr_en = wr_with_start; wr_addr = waddr; wr_data = wdata;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    if (len == 0) chk("len0_busy", {31'h0, busy}, 32'h0);
    if (abort_cyc >= 0) begin
      wait_until(abort_cyc);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_nop", {23'h0, issue_valid, instr_out}, 32'h0);
    end else begin
      if (pause_at > 0) begin
        wait_until(s + pause_at);
        ena = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ena = 1'b1;
      end
      if (wr_during && busy) begin
        wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = 16'($urandom);
        @(posedge clk); #1;
        wr_en = 1'b0;
      end
      wait_until(last + 1);
    end
    chk("queue_drained", expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    int l, ab, ps;
    bit ws, wd;
    for (int i = 0; i < 1024; i++) rin[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_outputs", {29'h0, obs[34:32]}, 32'h0);
    chk("reset_outputs_lo", obs[31:0], 32'h0);
    for (int i = 0; i < 16; i++) wr_prog(4'(i), 16'($urandom));

    // 1: LOAD/LOAD/MAC/MAC/EMIT with a forced result of 0x5A
    wr_prog(0, 16'h41FF); wr_prog(1, 16'h42AA); wr_prog(2, 16'h8155);
    wr_prog(3, 16'h8211); wr_prog(4, 16'hC022);
    force_en = 1'b1; force_val = 8'h5A;
    do_run(5, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);
    chk("t1_result", {24'h0, result_out}, 32'h5A);
    chk("t1_busy", {31'h0, busy}, 32'h0);
    force_en = 1'b0;

    // 2: EMIT, LOAD, EMIT with varying result_in
    wr_prog(0, 16'hC011); wr_prog(1, 16'h4433); wr_prog(2, 16'hC055);
    do_run(3, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);

    // 3: empty program
    do_run(0, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);

    // 4: abort on third issue, then restart from entry 0
    wr_prog(0, 16'h4101); wr_prog(1, 16'h4202); wr_prog(2, 16'h8303);
    wr_prog(3, 16'h8404); wr_prog(4, 16'h0005);
    do_run(5, 3, 0, 1'b0, 4'h0, 16'h0, 1'b0);
    do_run(5, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);

    // 5: enable held low mid-run, ignored write during run, read-back run,
    //    and a write coinciding with start
    do_run(5, 0, 2, 1'b0, 4'h0, 16'h0, 1'b1);
    do_run(5, 0, 0, 1'b1, 4'h0, 16'h7E7E, 1'b0);
    do_run(5, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);

    // 6: length clamp, then reset mid-run and confirm memory persists
    do_run(20, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);
    mon_off = 1'b1;
    prog_len = 5'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {29'h0, obs[34:32]}, 32'h0);
    chk("async_reset_outputs_lo", obs[31:0], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_off = 1'b0;
    do_run(16, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);

    // Randomized programs and run controls
    for (int r = 0; r < 24; r++) begin
      repeat (3) wr_prog(4'($urandom), 16'($urandom));
      l  = $urandom_range(0, 20);
      ab = ($urandom % 5 == 0) ? $urandom_range(1, 4) : 0;
      ps = (ab == 0 && $urandom % 3 == 0) ? $urandom_range(1, 6) : 0;
      ws = ($urandom % 4 == 0);
      wd = ($urandom % 3 == 0);
      do_run(l, ab, ps, ws, 4'($urandom), 16'($urandom), wd);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
